// File: rtl/uart_pkg.sv
// Shared 8N1 UART constants, serialiser state encoding and baud helper.
package uart_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned STOP_BITS  = 1;
    localparam logic        IDLE_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    // Clocks per bit; integer division truncates toward the faster rate.
    function automatic int unsigned baud_cnt_max(input int unsigned clk_freq,
                                                 input int unsigned uart_bps);
        return clk_freq / uart_bps;
    endfunction

endpackage

// File: rtl/uart_fifo_tx_if.sv
// Byte-strobe input, FIFO status and serial line of the buffered transmitter.
interface uart_fifo_tx_if
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic [DATA_BITS-1:0] pi_data;
    logic                 pi_flag;
    logic                 full;
    logic [LVL_W-1:0]     level;
    logic                 overflow;
    logic                 busy;
    logic                 tx;

    modport master (
        output pi_data, pi_flag,
        input  full, level, overflow, busy, tx
    );

    modport slave (
        input  pi_data, pi_flag,
        output full, level, overflow, busy, tx
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty/level; writes when full and
// reads when empty are ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push, pop;

    // Qualify requests against the registered flags and advance pointers/level.
    always_comb begin
        push     = wr_en && !full_q;
        pop      = rd_en && !empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        level_d = level_q + LVL_W'(push) - LVL_W'(pop);
        full_d  = (level_d == LVL_W'(DEPTH));
        empty_d = (level_d == '0);
    end

    // Pointer and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array; contents need no reset since empty gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;
    assign level   = level_q;

endmodule

// File: rtl/uart_fifo_tx.sv
// Buffered 8N1 UART transmitter: byte strobes queue in a FIFO and are
// serialised LSB first, with one idle clock between back-to-back frames.
module uart_fifo_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned UART_BPS = 9600,
    parameter int unsigned DEPTH    = 16
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    uart_fifo_tx_if.slave  bus
);

    localparam int unsigned BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
    localparam int unsigned CNT_W        = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
    localparam int unsigned IDX_W        = $clog2(DATA_BITS);
    localparam int unsigned LVL_W        = $clog2(DEPTH) + 1;

    localparam logic [CNT_W-1:0] BAUD_LAST  = CNT_W'(BAUD_CNT_MAX - 1);
    localparam logic [IDX_W-1:0] DATA_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST  = IDX_W'(STOP_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 overflow_q, overflow_d;
    logic                 baud_end;

    logic                 fifo_rd_en;
    logic [DATA_BITS-1:0] fifo_rd_data;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [LVL_W-1:0]     fifo_level;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .wr_en   (bus.pi_flag),
        .wr_data (bus.pi_data),
        .rd_en   (fifo_rd_en),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign baud_end = (cnt_q == BAUD_LAST);

    // Serialiser next state, baud/bit counters, shift register and line outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        fifo_rd_en = 1'b0;
        tx_d       = IDLE_LEVEL;
        busy_d     = 1'b0;
        overflow_d = overflow_q | (bus.pi_flag & fifo_full);

        if (state_q != IDLE) begin
            cnt_d = baud_end ? '0 : cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    shift_d    = fifo_rd_data;
                    cnt_d      = '0;
                    state_d    = START;
                end
            end
            START: begin
                if (baud_end) begin
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (baud_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == DATA_LAST) begin
                        bit_idx_d = '0;
                        state_d   = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                if (baud_end) begin
                    if (bit_idx_q == STOP_LAST) begin
                        bit_idx_d = '0;
                        state_d   = IDLE;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Line level follows the state being entered so tx stays registered.
        unique case (state_d)
            START:   tx_d = ~IDLE_LEVEL;
            DATA:    tx_d = shift_d[0];
            default: tx_d = IDLE_LEVEL;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= IDLE_LEVEL;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.tx       = tx_q;
    assign bus.busy     = busy_q;
    assign bus.overflow = overflow_q;
    assign bus.full     = fifo_full;
    assign bus.level    = fifo_level;

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Bench for uart_fifo_tx: a queue-and-waveform model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_uart_fifo_tx;

    localparam int unsigned DEPTH    = 16;
    localparam int unsigned BIT_CLKS = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_fifo_tx_if #(.DEPTH(DEPTH)) bus ();
    uart_fifo_tx_if #(.DEPTH(DEPTH)) bus2 ();

    uart_fifo_tx #(.CLK_FREQ(1000), .UART_BPS(100), .DEPTH(DEPTH)) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus)
    );

    uart_fifo_tx dut_def (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus2)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: byte queue plus the per-clock line waveform of the frame in flight.
    logic [7:0] mq [$];
    logic       wave [$];
    logic       m_tx   = 1'b1;
    logic       m_busy = 1'b0;
    logic       m_ovf  = 1'b0;
    bit         m_valid = 1'b0;
    logic [7:0] mb;
    logic       mv;
    bit         m_full_pre;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            wave.delete();
            m_tx    = 1'b1;
            m_busy  = 1'b0;
            m_ovf   = 1'b0;
            m_valid = 1'b1;
        end else begin
            m_full_pre = (mq.size() == DEPTH);
            if (!m_busy && mq.size() != 0) begin
                mb = mq.pop_front();
                for (int k = 0; k < 10; k++) begin
                    if (k == 0)      mv = 1'b0;
                    else if (k == 9) mv = 1'b1;
                    else             mv = mb[k-1];
                    for (int j = 0; j < BIT_CLKS; j++) wave.push_back(mv);
                end
            end
            if (bus.pi_flag) begin
                if (m_full_pre) m_ovf = 1'b1;
                else            mq.push_back(bus.pi_data);
            end
            if (wave.size() != 0) begin
                m_tx   = wave.pop_front();
                m_busy = 1'b1;
            end else begin
                m_tx   = 1'b1;
                m_busy = 1'b0;
            end
        end
    end

    // Every-cycle compare of the DUT against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_tx",       32'(bus.tx),       32'(m_tx));
            chk("m_busy",     32'(bus.busy),     32'(m_busy));
            chk("m_level",    32'(bus.level),    32'(mq.size()));
            chk("m_full",     32'(bus.full),     32'(mq.size() == DEPTH));
            chk("m_overflow", 32'(bus.overflow), 32'(m_ovf));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((bus.busy !== 1'b0 || bus.level !== '0) && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(n < budget), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int lows;
        bus.pi_flag  = 1'b0;
        bus.pi_data  = 8'h00;
        bus2.pi_flag = 1'b0;
        bus2.pi_data = 8'h00;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_tx",       32'(bus.tx),       32'd1);
        chk("rst_busy",     32'(bus.busy),     32'd0);
        chk("rst_level",    32'(bus.level),    32'd0);
        chk("rst_full",     32'(bus.full),     32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        rst = 1'b0;
        tick();

        // Single byte 0x55.
        bus.pi_data = 8'h55; bus.pi_flag = 1'b1;
        tick();                                   // edge N
        bus.pi_flag = 1'b0; bus.pi_data = 8'hC3;
        chk("single_level_n", 32'(bus.level), 32'd1);
        tick();                                   // N+1
        chk("single_start_tx",   32'(bus.tx),   32'd0);
        chk("single_start_busy", 32'(bus.busy), 32'd1);
        repeat (9) tick();                        // N+10
        chk("single_start_end", 32'(bus.tx), 32'd0);
        tick();                                   // N+11
        chk("single_bit0", 32'(bus.tx), 32'd1);
        repeat (10) tick();                       // N+21
        chk("single_bit1", 32'(bus.tx), 32'd0);
        repeat (79) tick();                       // N+100
        chk("single_stop_busy", 32'(bus.busy), 32'd1);
        chk("single_stop_tx",   32'(bus.tx),   32'd1);
        tick();                                   // N+101
        chk("single_done_busy", 32'(bus.busy), 32'd0);
        tick();

        // Burst of three bytes.
        bus.pi_flag = 1'b1; bus.pi_data = 8'hA5; tick();
        chk("burst_level1", 32'(bus.level), 32'd1);
        bus.pi_data = 8'h3C; tick();
        chk("burst_level2", 32'(bus.level), 32'd1);
        bus.pi_data = 8'hFF; tick();
        chk("burst_peak", 32'(bus.level), 32'd2);
        bus.pi_flag = 1'b0;
        n = 0;
        while (bus.level !== '0 && n < 300) begin tick(); n++; end
        chk("burst_third_pop_wait", 32'(n < 300), 32'd1);
        chk("burst_third_pop_busy", 32'(bus.busy), 32'd1);
        wait_idle("burst_idle_wait", 200);
        tick();

        // Overflow: 18 bytes into a 16-deep FIFO that pops the first at once.
        for (int i = 0; i < 18; i++) begin
            bus.pi_flag = 1'b1; bus.pi_data = 8'(i);
            tick();
            if (i == 15) begin
                chk("ovf_full_16th",  32'(bus.full),  32'd0);
                chk("ovf_level_16th", 32'(bus.level), 32'd15);
            end
            if (i == 16) begin
                chk("ovf_full_17th",  32'(bus.full),     32'd1);
                chk("ovf_level_17th", 32'(bus.level),    32'd16);
                chk("ovf_flag_17th",  32'(bus.overflow), 32'd0);
            end
            if (i == 17) begin
                chk("ovf_flag_18th",  32'(bus.overflow), 32'd1);
                chk("ovf_level_18th", 32'(bus.level),    32'd16);
            end
        end
        bus.pi_flag = 1'b0;
        wait_idle("ovf_idle_wait", 1900);
        chk("ovf_sticky", 32'(bus.overflow), 32'd1);
        rst = 1'b1; tick();
        chk("ovf_cleared", 32'(bus.overflow), 32'd0);
        rst = 1'b0; tick();

        // Write in the same cycle as a pop.
        bus.pi_flag = 1'b1; bus.pi_data = 8'h81; tick();
        chk("simul_level_pre", 32'(bus.level), 32'd1);
        bus.pi_data = 8'h7E; tick();
        chk("simul_level_same", 32'(bus.level), 32'd1);
        chk("simul_busy",       32'(bus.busy),  32'd1);
        bus.pi_flag = 1'b0;
        wait_idle("simul_idle_wait", 300);
        tick();

        // Reset during data bit 3 with four bytes buffered.
        for (int i = 0; i < 5; i++) begin
            bus.pi_flag = 1'b1; bus.pi_data = 8'(i * 17);
            tick();
        end
        bus.pi_flag = 1'b0;
        chk("midrst_level", 32'(bus.level), 32'd4);
        repeat (41) tick();                       // inside bit 3 of 0x00
        chk("midrst_bit3_tx", 32'(bus.tx), 32'd0);
        rst = 1'b1; tick();
        chk("midrst_tx",       32'(bus.tx),       32'd1);
        chk("midrst_level0",   32'(bus.level),    32'd0);
        chk("midrst_busy",     32'(bus.busy),     32'd0);
        chk("midrst_overflow", 32'(bus.overflow), 32'd0);
        rst = 1'b0;
        lows = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0) lows++;
        end
        chk("midrst_no_frames", 32'(lows), 32'd0);

        // Default parameters: start bit length in clocks.
        bus2.pi_data = 8'h01; bus2.pi_flag = 1'b1; tick();
        bus2.pi_flag = 1'b0;
        tick();
        chk("def_start_tx", 32'(bus2.tx), 32'd0);
        n = 0;
        while (bus2.tx === 1'b0 && n < 6000) begin tick(); n++; end
        chk("def_bit_clks", 32'(n), 32'd5208);
        chk("def_busy",     32'(bus2.busy), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
